// File: rtl/abs_value_arbiter.sv
// rtl/abs_value_arbiter.sv - round-robin shared 10-bit absolute-value unit
// Two-stage pipeline: S1 holds the accepted operand, S2 holds the tagged result.
module abs_value_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [10*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              out_result,
  output logic                    out_overflow,
  output logic [TAG_W-1:0]        out_tag,
  output logic [CNT_W-1:0]        ovf_count,
  input  logic                    ovf_clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [9:0]       s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [9:0]       s2_result_q, s2_result_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic             grant_found;
  logic [TAG_W-1:0] grant_idx;
  logic [9:0]       grant_data;
  int               arb_idx;
  logic             s2_load;
  logic             s1_free;
  logic             accept;
  logic [9:0]       abs_result;
  logic             abs_overflow;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    arb_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NUM_REQ) begin
        arb_idx = arb_idx - NUM_REQ;
      end
      if (!grant_found && req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(arb_idx);
        grant_data  = req_data[10*arb_idx +: 10];
      end
    end
  end

  always_comb begin
    s2_load = s1_valid_q & (~s2_valid_q | out_ready);
    s1_free = ~s1_valid_q | s2_load;
    // Ready is forced low while reset is asserted so no requester sees a phantom accept.
    accept  = grant_found & s1_free & reset_n;
    req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Two's complement negation of -512 wraps back to 10'h200, which is the required result.
  always_comb begin
    abs_result   = s1_data_q[9] ? (~s1_data_q + 10'd1) : s1_data_q;
    abs_overflow = (s1_data_q == 10'h200);
  end

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = accept | (s1_valid_q & ~s2_load);
    s1_data_d   = s1_data_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_load | (s2_valid_q & ~out_ready);
    s2_result_d = s2_result_q;
    s2_ovf_d    = s2_ovf_q;
    s2_tag_d    = s2_tag_q;
    ovf_count_d = ovf_count_q;

    if (accept) begin
      s1_data_d = grant_data;
      s1_tag_d  = grant_idx;
      ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    if (s2_load) begin
      s2_result_d = abs_result;
      s2_ovf_d    = abs_overflow;
      s2_tag_d    = s1_tag_q;
    end

    if (ovf_clear) begin
      ovf_count_d = '0;
    end else if (s2_valid_q && out_ready && s2_ovf_q && (ovf_count_q != CNT_MAX)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovf_q    <= 1'b0;
      s2_tag_q    <= '0;
      ovf_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_tag_q    <= s2_tag_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_overflow = s2_ovf_q;
  assign out_tag      = s2_tag_q;
  assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_abs_value_arbiter.sv
// tb/tb_abs_value_arbiter.sv - scoreboard bench for abs_value_arbiter
// Second instance with CNT_W=2 exercises counter saturation.
module tb_abs_value_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_result;
  logic        out_overflow;
  logic [1:0]  out_tag;
  logic [15:0] ovf_count;
  logic        ovf_clear;

  logic [3:0]  sat_req_valid;
  logic [39:0] sat_req_data;
  logic [3:0]  sat_req_ready;
  logic        sat_out_valid;
  logic        sat_out_ready;
  logic [9:0]  sat_out_result;
  logic        sat_out_overflow;
  logic [1:0]  sat_out_tag;
  logic [1:0]  sat_ovf_count;
  logic        sat_ovf_clear;

  int          tests;
  int          fails;
  int          acc_cnt;
  logic        m_s1;
  logic        m_s2;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [12:0] sb[$];

  abs_value_arbiter #(.NUM_REQ(4), .TAG_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_tag(out_tag),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  abs_value_arbiter #(.NUM_REQ(4), .TAG_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .req_valid(sat_req_valid), .req_data(sat_req_data),
    .req_ready(sat_req_ready), .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .out_result(sat_out_result), .out_overflow(sat_out_overflow), .out_tag(sat_out_tag),
    .ovf_count(sat_ovf_count), .ovf_clear(sat_ovf_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] exp_abs(input logic [9:0] d);
    logic [10:0] m;
    m = 11'd1024 - {1'b0, d};
    if (d == 10'h200) return {1'b1, 10'h200};
    if (d[9]) return {1'b0, m[9:0]};
    return {1'b0, d};
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    sb.delete();
  endtask

  // One clock: check DUT against the model at negedge, then advance the model.
  task automatic tick();
    logic [3:0]  exp_ready;
    logic [12:0] e;
    logic        s2_load, s1_free, found, deliver, acc;
    int          g;
    e = '0;
    @(negedge clk);
    s2_load = m_s1 && (!m_s2 || out_ready);
    s1_free = !m_s1 || s2_load;
    found = 1'b0;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    acc = found && s1_free;
    exp_ready = acc ? 4'(1 << g) : 4'b0000;
    tests++;
    if (req_ready !== exp_ready) begin
      fails++;
      $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
    end
    tests++;
    if (out_valid !== m_s2) begin
      fails++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_s2);
    end
    tests++;
    if (ovf_count !== m_cnt) begin
      fails++;
      $display("FAIL ovf_count: got %0d expected %0d", ovf_count, m_cnt);
    end
    deliver = m_s2 && out_ready;
    if (deliver) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: got result %h expected none", out_result);
      end else begin
        e = sb.pop_front();
        if (out_result !== e[9:0] || out_overflow !== e[10] || out_tag !== e[12:11]) begin
          fails++;
          $display("FAIL result: got tag %0d res %h ovf %b expected tag %0d res %h ovf %b",
                   out_tag, out_result, out_overflow, e[12:11], e[9:0], e[10]);
        end
      end
    end
    if (acc) begin
      sb.push_back({2'(g), exp_abs(req_data[10*g +: 10])});
      m_ptr = (g + 1) % 4;
      acc_cnt++;
    end
    if (ovf_clear) m_cnt = '0;
    else if (deliver && e[10] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_s2 = s2_load || (m_s2 && !out_ready);
    m_s1 = acc || (m_s1 && !s2_load);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || m_s1 || m_s2); i++) tick();
    tests++;
    if (sb.size() != 0 || m_s1 || m_s2) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 4'b1111;
    #12;
    tests += 6;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_result !== 10'h000) begin fails++; $display("FAIL reset_out_result: got %h expected 000", out_result); end
    if (out_overflow !== 1'b0) begin fails++; $display("FAIL reset_out_overflow: got %b expected 0", out_overflow); end
    if (out_tag !== 2'd0) begin fails++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
    if (ovf_count !== 16'd0) begin fails++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_data[29:20] = 10'h3FF;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    drain();
  endtask

  task automatic test_round_robin();
    int start;
    req_data = {10'h3F8, 10'd7, 10'h3FA, 10'd5};
    out_ready = 1'b1;
    req_valid = 4'b1111;
    start = acc_cnt;
    for (int i = 0; i < 12; i++) tick();
    tests++;
    if (acc_cnt - start != 12) begin
      fails++;
      $display("FAIL rr_accept_rate: got %0d expected 12", acc_cnt - start);
    end
    drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    req_data[19:10] = 10'h200;
    req_valid = 4'b0010;
    tick();
    req_data[19:10] = 10'h1FF;
    tick();
    drain();
    tests++;
    if (ovf_count !== 16'd1) begin fails++; $display("FAIL ovf_count_one: got %0d expected 1", ovf_count); end
    req_data[19:10] = 10'h200;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    tick();
    tests++;
    if (ovf_count !== 16'd0) begin fails++; $display("FAIL ovf_clear_priority: got %0d expected 0", ovf_count); end
    drain();
  endtask

  task automatic test_backpressure();
    int start;
    logic [12:0] snap;
    req_data = {10'h301, 10'h0AA, 10'h200, 10'h155};
    out_ready = 1'b0;
    req_valid = 4'b1111;
    start = acc_cnt;
    tick();
    tick();
    snap = {out_tag, out_overflow, out_result};
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({out_tag, out_overflow, out_result} !== snap) begin
        fails++;
        $display("FAIL stall_stable: got %h expected %h", {out_tag, out_overflow, out_result}, snap);
      end
    end
    tests++;
    if (acc_cnt - start != 2) begin
      fails++;
      $display("FAIL stall_accepts: got %0d expected 2", acc_cnt - start);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drain();
  endtask

  task automatic test_saturation();
    int accepts, deliveries;
    logic pending;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    accepts = 0;
    deliveries = 0;
    pending = 1'b0;
    sat_req_data[9:0] = 10'h200;
    sat_out_ready = 1'b1;
    sat_req_valid = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pending) begin
        tests++;
        if (sat_ovf_count !== exp_cnt[deliveries-1]) begin
          fails++;
          $display("FAIL sat_count_%0d: got %0d expected %0d", deliveries, sat_ovf_count, exp_cnt[deliveries-1]);
        end
        pending = 1'b0;
      end
      if (sat_out_valid) begin
        deliveries++;
        pending = 1'b1;
      end
      if (sat_req_ready[0]) accepts++;
      @(posedge clk);
      #1;
      if (accepts >= 5) sat_req_valid = 4'b0000;
      if (deliveries == 5 && !pending) break;
    end
    tests++;
    if (deliveries != 5) begin fails++; $display("FAIL sat_deliveries: got %0d expected 5", deliveries); end
  endtask

  task automatic test_reset_midflight();
    req_data = {10'd40, 10'd30, 10'd20, 10'd10};
    out_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    if (ovf_count !== 16'd0) begin fails++; $display("FAIL midreset_ovf_count: got %0d expected 0", ovf_count); end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL midreset_first_grant: got %b expected 0001", req_ready); end
    for (int i = 0; i < 4; i++) tick();
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    acc_cnt = 0;
    reset_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    sat_req_valid = '0;
    sat_req_data = '0;
    sat_out_ready = 1'b0;
    sat_ovf_clear = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
